tdes_block_packer: RTL

- Input-side counterpart of the 3DES output word selector: collects 16-bit words and assembles them into the 64-bit message, K1 and K2 operands the 3DES core consumes.
- Emits one complete block, with keys and mode, to the core over a valid/ready handshake.
- Sits between the host/switch interface and the Triple-DES datapath.
- Word 0 of each field maps to bits [1:16] (MSB-first, DES bit numbering); word 3 maps to bits [49:64].

---
 rtl/tdes_block_packer.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/tdes_block_packer.sv
// tdes_block_packer: gathers 16-bit host words into message/K1/K2
// fields and hands one complete 3DES block to the core per handshake.
module tdes_block_packer #(
  parameter int WORD_W = 16,
  parameter int WORDS  = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [1:WORD_W]          in_word,
  input  logic [1:2]               in_dest,
  input  logic                     select,
  output logic                     blk_valid,
  input  logic                     blk_ready,
  output logic [1:WORD_W*WORDS]    message,
  output logic [1:WORD_W*WORDS]    K1,
  output logic [1:WORD_W*WORDS]    K2,
  output logic                     mode,
  output logic                     keys_loaded,
  output logic                     err
);

  localparam int FW = WORD_W * WORDS;
  localparam int CW = $clog2(WORDS);

  typedef enum logic {COLLECT, ISSUE} state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q;
  logic [1:2]      cur_q;
  logic [1:FW]     msg_sh_q, k1_sh_q, k2_sh_q;
  logic [1:FW]     msg_q, k1_q, k2_q;
  logic            mode_q, k1_ok_q, k2_ok_q, err_q;

  logic            acc, rsvd, chg, last;
  logic            is_msg, is_k1, is_k2;
  logic            keys_ok, issue_go, err_d;
  logic [CW-1:0]   idx;
  logic [1:FW]     base, filled;

  function automatic logic [1:FW] put(
    input logic [1:FW]     v,
    input logic [CW-1:0]   i,
    input logic [1:WORD_W] w
  );
    logic [1:FW] r;
    r = v;
    r[int'(i)*WORD_W+1 +: WORD_W] = w;
    return r;
  endfunction

  assign acc      = in_valid && in_ready;
  assign rsvd     = (in_dest == 2'b11);
  assign is_msg   = (in_dest == 2'b00);
  assign is_k1    = (in_dest == 2'b01);
  assign is_k2    = (in_dest == 2'b10);
  // a new destination mid-field restarts at word 0 of that field
  assign chg      = (cnt_q != '0) && (in_dest != cur_q);
  assign idx      = chg ? '0 : cnt_q;
  assign last     = (idx == CW'(WORDS - 1));
  assign keys_ok  = k1_ok_q && k2_ok_q;
  assign issue_go = acc && is_msg && last && keys_ok;
  assign err_d    = acc && (rsvd || chg ||
                    (is_msg && last && !keys_ok));

  // merge the incoming word into the addressed field's shadow
  always_comb begin
    base = msg_sh_q;
    unique case (1'b1)
      is_k1:   base = k1_sh_q;
      is_k2:   base = k2_sh_q;
      default: base = msg_sh_q;
    endcase
    filled = put(base, idx, in_word);
  end

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= COLLECT;
    else        state_q <= state_d;
  end

  // next-state: a completed message issues, core acceptance returns
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      COLLECT: if (issue_go)  state_d = ISSUE;
      ISSUE:   if (blk_ready) state_d = COLLECT;
      default: state_d = COLLECT;
    endcase
  end

  // handshake outputs; no words accepted while reset is held
  always_comb begin
    in_ready  = rst_n && (state_q == COLLECT);
    blk_valid = (state_q == ISSUE);
  end

  // field assembly, key commit and block capture
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q    <= '0;
      cur_q    <= '0;
      msg_sh_q <= '0;
      k1_sh_q  <= '0;
      k2_sh_q  <= '0;
      msg_q    <= '0;
      k1_q     <= '0;
      k2_q     <= '0;
      mode_q   <= 1'b0;
      k1_ok_q  <= 1'b0;
      k2_ok_q  <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      err_q <= err_d;
      if (acc) begin
        if (rsvd) begin
          cnt_q <= '0;
        end else begin
          cur_q <= in_dest;
          cnt_q <= last ? '0 : idx + 1'b1;
          unique case (1'b1)
            is_k1: begin
              k1_sh_q <= filled;
              if (last) begin
                k1_q    <= filled;
                k1_ok_q <= 1'b1;
              end
            end
            is_k2: begin
              k2_sh_q <= filled;
              if (last) begin
                k2_q    <= filled;
                k2_ok_q <= 1'b1;
              end
            end
            default: begin
              msg_sh_q <= filled;
              if (issue_go) begin
                msg_q  <= filled;
                mode_q <= select;
              end
            end
          endcase
        end
      end
    end
  end

  assign message     = msg_q;
  assign K1          = k1_q;
  assign K2          = k2_q;
  assign mode        = mode_q;
  assign keys_loaded = keys_ok;
  assign err         = err_q;

endmodule
